// File: rtl/modmul_interleaved.sv
// modmul_interleaved: radix-2 interleaved modular multiplier, result = (a*b) mod m.
// The multiplier b is consumed MSB first, one bit per clock, so a normal
// operation takes WIDTH+2 edges from an accepted start to the done pulse.
// The running partial product stays in [0,m) after every step.
// Optional feature macro: MODMUL_INV_CHECK_EN builds the result==1 flag on
// is_one. Without the macro, is_one is tied to 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; operands latched and checked on accept
// S_RUN  | one multiplier bit per cycle: P = (2P + b_bit*a) mod m
// S_FIN  | publish result/err/is_one, pulse done, drop busy

module modmul_interleaved #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err,
   output logic             is_one
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // 2P + a < 3m < 2^(WIDTH+2), so two guard bits keep the sum exact
   localparam int DW = WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [DW-1:0]    m_ext;
   logic [DW-1:0]    t_add;
   logic [DW-1:0]    t_sub1;
   logic [WIDTH-1:0] p_next;
   logic             op_bad;

`ifdef MODMUL_INV_CHECK_EN
   logic             is_one_q, is_one_d;
`endif

   // One interleaved step: double, add a if the current multiplier bit is set,
   // then fold back into [0,m) with at most two conditional subtractions.
   // b_q is a left-shifting copy of b, so its MSB is always the bit in use.
   always_comb begin
      m_ext  = {2'b00, m_q};
      t_add  = {1'b0, p_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : {DW{1'b0}});
      t_sub1 = (t_add >= m_ext) ? (t_add - m_ext) : t_add;
      p_next = WIDTH'((t_sub1 >= m_ext) ? (t_sub1 - m_ext) : t_sub1);
   end

   // Operand check, evaluated on the live inputs at the accepting edge.
   always_comb begin
      op_bad = (m == {WIDTH{1'b0}}) || (a >= m) || (b >= m);
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      p_d      = p_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
`ifdef MODMUL_INV_CHECK_EN
      is_one_d = is_one_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               m_d      = m;
               p_d      = {WIDTH{1'b0}};
               cnt_d    = CW'(WIDTH - 1);
               result_d = {WIDTH{1'b0}};
               err_d    = op_bad;
               busy_d   = 1'b1;
`ifdef MODMUL_INV_CHECK_EN
               is_one_d = 1'b0;
`endif
               state_d  = op_bad ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            p_d   = p_next;
            b_d   = {b_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == {CW{1'b0}}) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            result_d = err_q ? {WIDTH{1'b0}} : p_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
`ifdef MODMUL_INV_CHECK_EN
            is_one_d = (p_q == WIDTH'(1)) && !err_q;
`endif
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         p_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef MODMUL_INV_CHECK_EN
         is_one_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         p_q      <= p_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef MODMUL_INV_CHECK_EN
         is_one_q <= is_one_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;
`ifdef MODMUL_INV_CHECK_EN
   assign is_one = is_one_q;
`else
   assign is_one = 1'b0;
`endif

endmodule
